popcount_accumulator: RTL

Streaming stage directly downstream of bit_counter. Accepts data words over a valid/ready handshake, popcounts each word with one bit_counter instance, and accumulates set-bit totals across a frame delimited by in_last. Presents a registered per-frame result (total ones, beat count, saturation flag) on a valid/ready output with a one-entry output buffer. Used for frame density/weight statistics.

---
 rtl/popcount_pkg.sv | 27 ++
 rtl/bit_counter.sv | 24 ++
 rtl/popcount_accumulator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// Shared types and helpers for the frame popcount accumulator.
// sat_add works on a fixed 32-bit datapath; callers pass the real field width.
package popcount_pkg;

    localparam int unsigned SAT_W = 32;

    typedef enum logic {IDLE, ACCUM} pacc_state_e;

    function automatic int unsigned pop_width(input int unsigned data_width);
        return $clog2(data_width) + 1;
    endfunction

    // Returns {overflow, saturated_sum}; the sum is clamped to 2^width-1.
    function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      width);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
        if (sum > max) begin
            return {1'b1, max[SAT_W-1:0]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Combinational population count; result split as {carry_out, data_out}
// so an all-ones word reports DATA_WIDTH through the carry bit.
module bit_counter #(
    parameter int INPUTBITWIDTH = 16
) (
    input  logic [INPUTBITWIDTH-1:0]         data_in,
    output logic [$clog2(INPUTBITWIDTH)-1:0] data_out,
    output logic                             carry_out
);

    localparam int CW = $clog2(INPUTBITWIDTH) + 1;

    logic [CW-1:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < INPUTBITWIDTH; i++) begin
            cnt = cnt + CW'(data_in[i]);
        end
    end

    assign {carry_out, data_out} = cnt;

endmodule

// File: rtl/popcount_accumulator.sv
// Accumulates per-word popcounts across a frame and presents a buffered
// {count, beats, sat} result per frame on a valid/ready output.
//
// state | meaning
// IDLE  | no partial frame held (beats == 0)
// ACCUM | at least one word of the current frame accepted
module popcount_accumulator
    import popcount_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 16,
    parameter int BEAT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_count,
    output logic [BEAT_WIDTH-1:0] out_beats,
    output logic                  out_sat
);

    localparam int POP_W = pop_width(DATA_WIDTH);

    pacc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [BEAT_WIDTH-1:0] beats_q, beats_d;
    logic                  sat_q, sat_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]  out_count_q, out_count_d;
    logic [BEAT_WIDTH-1:0] out_beats_q, out_beats_d;
    logic                  out_sat_q, out_sat_d;

    logic [POP_W-1:0]      pop;
    logic [SAT_W:0]        acc_add;
    logic [SAT_W:0]        beats_add;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [BEAT_WIDTH-1:0] beats_next;
    logic                  sat_next;
    logic                  in_fire;
    logic                  out_fire;
    logic                  acc_fire;

    bit_counter #(
        .INPUTBITWIDTH(DATA_WIDTH)
    ) u_bit_counter (
        .data_in  (in_data),
        .data_out (pop[POP_W-2:0]),
        .carry_out(pop[POP_W-1])
    );

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    // A word handshaken during clear is consumed but contributes nothing.
    assign acc_fire = in_fire && !clear;

    always_comb begin
        acc_add    = sat_add(SAT_W'(acc_q), SAT_W'(pop), ACC_WIDTH);
        beats_add  = sat_add(SAT_W'(beats_q), SAT_W'(1), BEAT_WIDTH);
        acc_next   = acc_add[ACC_WIDTH-1:0];
        beats_next = beats_add[BEAT_WIDTH-1:0];
        // Any bit above the field width also counts as an overflow.
        sat_next   = sat_q
                   | acc_add[SAT_W]   | (|acc_add[SAT_W-1:ACC_WIDTH])
                   | beats_add[SAT_W] | (|beats_add[SAT_W-1:BEAT_WIDTH]);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_beats_d = out_beats_q;
        out_sat_d   = out_sat_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            beats_d = '0;
            sat_d   = 1'b0;
        end else if (acc_fire) begin
            if (in_last) begin
                state_d     = IDLE;
                acc_d       = '0;
                beats_d     = '0;
                sat_d       = 1'b0;
                out_valid_d = 1'b1;
                out_count_d = acc_next;
                out_beats_d = beats_next;
                out_sat_d   = sat_next;
            end else begin
                state_d = ACCUM;
                acc_d   = acc_next;
                beats_d = beats_next;
                sat_d   = sat_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            beats_q     <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_beats_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_beats_q <= out_beats_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_beats = out_beats_q;
    assign out_sat   = out_sat_q;

    // The beat counter saturates rather than wraps, so it is never 0 in ACCUM.
    a_state_matches_beats: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ACCUM) == (beats_q != '0));

endmodule
